// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, controller states and the error byte.
// Imported by the UART controller and the external ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [3:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND_RES,
        S_WAIT_TX_RES,
        S_SEND_FLG,
        S_WAIT_TX_FLG,
        S_SEND_ERR,
        S_WAIT_TX_ERR
    } state_t;

    typedef enum logic [1:0] {
        TX_RES,
        TX_FLG,
        TX_ERR
    } tx_sel_t;

    function automatic logic op_valid(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// UART byte handshake between the ALU controller and the UART rx/tx pair.
// ctrl is the controller side, uart the transceiver side.
interface alu_uart_ctrl_if;

    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;

    modport ctrl (
        input  rx_done,
        input  rx_data,
        input  tx_done,
        output tx_start,
        output tx_data
    );

    modport uart (
        output rx_done,
        output rx_data,
        output tx_done,
        input  tx_start,
        input  tx_data
    );

endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects A, B and opcode bytes from the UART, drives the external ALU,
// then sends back the result byte and the flag byte (or 0xEE on a bad op).
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int NB_OP = 6
) (
    input  logic             clk,
    input  logic             reset,
    alu_uart_ctrl_if.ctrl    uart,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [NB_OP-1:0] alu_op,
    output logic             busy
);

    state_t           state_q;
    tx_sel_t          sel_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [NB_OP-1:0] op_q;
    logic [N-1:0]     res_q;
    logic [7:0]       flg_q;
    logic             tx_start_q;
    logic             busy_q;

    logic [5:0] op_byte;
    logic [7:0] res_byte;
    logic       unused_op_hi;

    // Opcode bits [7:6] are don't-care on the wire.
    assign op_byte      = uart.rx_data[5:0];
    assign unused_op_hi = ^uart.rx_data[7:6];
    assign res_byte     = 8'(res_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT_A;
            sel_q      <= TX_RES;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            flg_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                S_WAIT_A: begin
                    if (uart.rx_done) begin
                        a_q     <= N'(uart.rx_data);
                        state_q <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (uart.rx_done) begin
                        b_q     <= N'(uart.rx_data);
                        state_q <= S_WAIT_OP;
                    end
                end
                S_WAIT_OP: begin
                    if (uart.rx_done) begin
                        busy_q <= 1'b1;
                        if (op_valid(op_byte)) begin
                            op_q    <= NB_OP'(op_byte);
                            state_q <= S_EXEC;
                        end else begin
                            sel_q      <= TX_ERR;
                            tx_start_q <= 1'b1;
                            state_q    <= S_SEND_ERR;
                        end
                    end
                end
                // Start is raised here so it is high during SEND_RES.
                S_EXEC: begin
                    res_q      <= alu_result;
                    flg_q      <= {5'b0, alu_carry, alu_overflow, alu_zero};
                    sel_q      <= TX_RES;
                    tx_start_q <= 1'b1;
                    state_q    <= S_SEND_RES;
                end
                S_SEND_RES: state_q <= S_WAIT_TX_RES;
                S_WAIT_TX_RES: begin
                    if (uart.tx_done) begin
                        sel_q      <= TX_FLG;
                        tx_start_q <= 1'b1;
                        state_q    <= S_SEND_FLG;
                    end
                end
                S_SEND_FLG: state_q <= S_WAIT_TX_FLG;
                S_SEND_ERR: state_q <= S_WAIT_TX_ERR;
                S_WAIT_TX_FLG, S_WAIT_TX_ERR: begin
                    if (uart.tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_WAIT_A;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_WAIT_A;
                end
            endcase
        end
    end

    always_comb begin
        uart.tx_data = res_byte;
        unique case (sel_q)
            TX_FLG:  uart.tx_data = flg_q;
            TX_ERR:  uart.tx_data = ERR_BYTE;
            default: uart.tx_data = res_byte;
        endcase
    end

    assign uart.tx_start = tx_start_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_op        = op_q;
    assign busy          = busy_q;

endmodule
